// File: rtl/garnet_reset_sequencer.sv
// Staggered multi-channel reset sequencer with req/ack re-run, heartbeat pulse and cycle counter.
// Runs the full-mask power-on sequence after reset, then reruns with a software channel mask on request.

module garnet_rst_lane (
  input  logic clk,
  input  logic reset,
  input  logic set_i,
  input  logic mask_i,
  input  logic rel_i,
  output logic rst_o
);
  logic rst_d, rst_q;

  always_comb begin
    rst_d = rst_q;
    if (set_i)      rst_d = mask_i;
    else if (rel_i) rst_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) rst_q <= 1'b0;
    else       rst_q <= rst_d;
  end

  assign rst_o = rst_q;
endmodule

module garnet_reset_sequencer #(
  parameter int NUM_CH           = 4,
  parameter int CNT_WIDTH        = 8,
  parameter int PRE_CYCLES       = 3,
  parameter int ASSERT_CYCLES    = 3,
  parameter int STAGGER_CYCLES   = 2,
  parameter int HEARTBEAT_PERIOD = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_req,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              start_ack,
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy,
  output logic              done,
  output logic              heartbeat,
  output logic [31:0]       cycle_count
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HB_W  = $clog2(HEARTBEAT_PERIOD);

  localparam logic [CNT_WIDTH-1:0] PRE_C    = CNT_WIDTH'(PRE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ASSERT_C = CNT_WIDTH'(ASSERT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] STAG_C   = CNT_WIDTH'(STAGGER_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
  localparam logic [NUM_CH-1:0]    CH_ONE   = NUM_CH'(1);
  localparam logic [HB_W-1:0]      HB_LAST  = HB_W'(HEARTBEAT_PERIOD - 1);
  localparam logic [HB_W-1:0]      HB_ONE   = HB_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ASSERT, S_RELEASE} state_e;

  state_e                state_d, state_q;
  logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;
  logic [IDX_W-1:0]      idx_d, idx_q;
  logic [NUM_CH-1:0]     mask_d, mask_q;
  logic                  busy_d, busy_q;
  logic                  done_d, done_q;
  logic                  ack_d, ack_q;
  logic                  hb_d, hb_q;
  logic [HB_W-1:0]       hb_cnt_d, hb_cnt_q;
  logic [31:0]           cyc_d, cyc_q;
  logic                  set_all;
  logic                  finish;
  logic [NUM_CH-1:0]     rel_vec;

  // Power-on counts the first unreset edge as edge 0 of PRE (cnt 0), while a
  // software accept enters PRE with cnt 1, so both land on the mask at T+PRE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    set_all = 1'b0;
    finish  = 1'b0;
    rel_vec = '0;
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          ack_d   = 1'b1;
          mask_d  = ch_mask;
          busy_d  = 1'b1;
          cnt_d   = CNT_ONE;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (cnt_q == PRE_C) begin
          set_all = 1'b1;
          cnt_d   = CNT_ONE;
          state_d = S_ASSERT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ASSERT: begin
        if (cnt_q == ASSERT_C) begin
          if (STAGGER_CYCLES == 0 || NUM_CH == 1) begin
            rel_vec = '1;
            finish  = 1'b1;
          end else begin
            rel_vec = CH_ONE;
            idx_d   = IDX_ONE;
            cnt_d   = CNT_ONE;
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RELEASE: begin
        if (cnt_q == STAG_C) begin
          rel_vec = CH_ONE << idx_q;
          if (idx_q == LAST_IDX) begin
            finish = 1'b1;
          end else begin
            idx_d = idx_q + IDX_ONE;
            cnt_d = CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (finish) begin
      busy_d  = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
      state_d = S_IDLE;
    end
    done_d = finish;
  end

  // Heartbeat tracks cycle_count modulo the period without a divider.
  always_comb begin
    cyc_d = cyc_q + 32'd1;
    hb_d  = 1'b0;
    if (hb_cnt_q == HB_LAST) begin
      hb_cnt_d = '0;
      hb_d     = 1'b1;
    end else begin
      hb_cnt_d = hb_cnt_q + HB_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_PRE;
      cnt_q    <= '0;
      idx_q    <= '0;
      mask_q   <= '1;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      hb_q     <= 1'b0;
      hb_cnt_q <= '0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      hb_q     <= hb_d;
      hb_cnt_q <= hb_cnt_d;
      cyc_q    <= cyc_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    garnet_rst_lane u_lane (
      .clk    (clk),
      .reset  (reset),
      .set_i  (set_all),
      .mask_i (mask_q[i]),
      .rel_i  (rel_vec[i]),
      .rst_o  (rst_out[i])
    );
  end

  assign start_ack   = ack_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign heartbeat   = hb_q;
  assign cycle_count = cyc_q;
endmodule

// File: tb/tb_garnet_reset_sequencer.sv
// Scoreboard bench: a timeline model predicts every cycle's outputs for two sequencers
// (stagger 2 and stagger 0); a negedge monitor pops and compares.
module tb_garnet_reset_sequencer;
  localparam int NCH  = 4;
  localparam int PRE  = 3;
  localparam int ASRT = 3;
  localparam int HBP  = 100;

  typedef struct packed {
    logic [3:0]  rst;
    logic        busy;
    logic        done;
    logic        ack;
    logic        hb;
    logic [31:0] cyc;
  } exp_t;

  typedef struct {
    int          since;
    logic [3:0]  m;
    bit          in_run;
    bit          pend;
    logic [31:0] cyc;
  } mdl_t;

  logic        clk = 1'b0;
  logic        reset, start_req;
  logic [3:0]  mask_a, mask_b;
  logic        a_ack, a_busy, a_done, a_hb, b_ack, b_busy, b_done, b_hb;
  logic [3:0]  a_rst, b_rst;
  logic [31:0] a_cyc, b_cyc;

  exp_t qa[$], qb[$];
  mdl_t ma, mb;
  int   nvec = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  garnet_reset_sequencer #(.NUM_CH(NCH), .CNT_WIDTH(8), .PRE_CYCLES(PRE), .ASSERT_CYCLES(ASRT),
                           .STAGGER_CYCLES(2), .HEARTBEAT_PERIOD(HBP)) u_dut_a (
    .clk(clk), .reset(reset), .start_req(start_req), .ch_mask(mask_a), .start_ack(a_ack),
    .rst_out(a_rst), .busy(a_busy), .done(a_done), .heartbeat(a_hb), .cycle_count(a_cyc));

  garnet_reset_sequencer #(.NUM_CH(NCH), .CNT_WIDTH(8), .PRE_CYCLES(PRE), .ASSERT_CYCLES(ASRT),
                           .STAGGER_CYCLES(0), .HEARTBEAT_PERIOD(HBP)) u_dut_b (
    .clk(clk), .reset(reset), .start_req(start_req), .ch_mask(mask_b), .start_ack(b_ack),
    .rst_out(b_rst), .busy(b_busy), .done(b_done), .heartbeat(b_hb), .cycle_count(b_cyc));

  // Model: each run is a timeline measured in edges since its trigger edge.
  task automatic model_step(input int stag, input logic rst_in, input logic req,
                            input logic [3:0] cm, input mdl_t si, output mdl_t so, output exp_t e);
    int last;
    so = si;
    e  = '0;
    last = PRE + ASRT + (NCH - 1) * stag;
    if (rst_in) begin
      so.pend = 1; so.in_run = 1; so.m = 4'hF; so.since = 0; so.cyc = 0;
      e.busy = 1'b1;
    end else begin
      so.cyc = si.cyc + 32'd1;
      if (si.pend) begin
        so.pend = 0; so.since = 0;
      end else if (si.in_run) begin
        so.since = si.since + 1;
      end else if (req) begin
        e.ack = 1'b1; so.m = cm; so.since = 0; so.in_run = 1;
      end
      if (so.in_run) begin
        for (int i = 0; i < NCH; i++)
          e.rst[i] = so.m[i] && (so.since >= PRE) && (so.since < PRE + ASRT + i * stag);
        if (so.since == last) begin
          e.done = 1'b1; so.in_run = 0;
        end
      end
      e.busy = so.in_run;
      e.cyc  = so.cyc;
      e.hb   = (so.cyc != 0) && (so.cyc % HBP == 0);
    end
  endtask

  task automatic tick();
    mdl_t na, nb;
    exp_t ea, eb;
    @(posedge clk);
    model_step(2, reset, start_req, mask_a, ma, na, ea);
    ma = na; qa.push_back(ea);
    model_step(0, reset, start_req, mask_b, mb, nb, eb);
    mb = nb; qb.push_back(eb);
    #1;
  endtask

  task automatic check(input string name, input exp_t got, input exp_t exp);
    nvec++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s vec%0d: got rst=%b busy=%b done=%b ack=%b hb=%b cyc=%0d, expected rst=%b busy=%b done=%b ack=%b hb=%b cyc=%0d",
               name, nvec, got.rst, got.busy, got.done, got.ack, got.hb, got.cyc,
               exp.rst, exp.busy, exp.done, exp.ack, exp.hb, exp.cyc);
    end
  endtask

  always begin
    exp_t ea, eb, ga, gb;
    @(negedge clk);
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      ga.rst = a_rst; ga.busy = a_busy; ga.done = a_done; ga.ack = a_ack; ga.hb = a_hb; ga.cyc = a_cyc;
      check("stag2", ga, ea);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      gb.rst = b_rst; gb.busy = b_busy; gb.done = b_done; gb.ack = b_ack; gb.hb = b_hb; gb.cyc = b_cyc;
      check("stag0", gb, eb);
    end
  end

  initial begin
    reset = 1'b1; start_req = 1'b0; mask_a = 4'h0; mask_b = 4'h0;
    repeat (3) tick();
    // power-on sequence
    reset = 1'b0;
    repeat (16) tick();
    // software run, then a request held across the busy window and the done edge
    mask_a = 4'b0101; mask_b = 4'b0000; start_req = 1'b1;
    tick();
    start_req = 1'b0; mask_a = 4'b1010;
    repeat (3) tick();
    start_req = 1'b1; mask_a = 4'b0011;
    repeat (12) tick();
    start_req = 1'b0;
    repeat (20) tick();
    // reset in the middle of the power-on run
    reset = 1'b1; repeat (2) tick();
    reset = 1'b0; repeat (7) tick();
    reset = 1'b1; repeat (2) tick();
    reset = 1'b0; repeat (16) tick();
    // heartbeat over 350 cycles with a software run at cycle 150
    reset = 1'b1; tick();
    reset = 1'b0;
    for (int c = 1; c <= 350; c++) begin
      start_req = (c == 150); mask_a = 4'b1001; mask_b = 4'b0110;
      tick();
    end
    start_req = 1'b0;
    // random traffic
    for (int k = 0; k < 400; k++) begin
      reset     = ($urandom_range(0, 199) == 0);
      start_req = ($urandom_range(0, 5) == 0);
      mask_a    = 4'($urandom);
      mask_b    = 4'($urandom);
      tick();
    end
    reset = 1'b0; start_req = 1'b0;
    repeat (2) @(negedge clk);
    if (qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d expected entries left, required 0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end
endmodule

// File: doc/garnet_reset_sequencer.md
Name: garnet_reset_sequencer

Overview:
Parametrised reset/heartbeat sequencer for Garnet test and bring-up environments. It generalises the fixed three-low/three-high reset stimulus into a synthesizable block driving NUM_CH staggered reset outputs. Re-runs are software-triggered through a req/ack handshake with a channel mask. It also produces a periodic heartbeat pulse and a free-running cycle counter for progress logging.

Parameters:
NUM_CH, 4, number of reset output channels (1..16)
CNT_WIDTH, 8, width of internal phase counters
PRE_CYCLES, 3, cycles rst_out stays low after trigger (>=1, < 2^CNT_WIDTH)
ASSERT_CYCLES, 3, cycles all masked channels are held high before the first release (>=1)
STAGGER_CYCLES, 2, extra cycles between release of channel i and channel i+1 (>=0; 0 = simultaneous)
HEARTBEAT_PERIOD, 100, cycles between heartbeat pulses (>=2)

Ports:
clk  input  1  single clock
reset  input  1  synchronous, active-high reset
start_req  input  1  request to re-run the sequence
ch_mask  input  NUM_CH  channels to drive in a software-triggered run; latched on acceptance
start_ack  output  1  one-cycle pulse; request accepted
rst_out  output  NUM_CH  per-channel reset outputs, active-high, registered
busy  output  1  sequence in progress
done  output  1  one-cycle pulse; sequence complete
heartbeat  output  1  one-cycle pulse every HEARTBEAT_PERIOD cycles
cycle_count  output  32  cycles since reset release, wraps at 2^32

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: rst_out=0, busy=1 (power-on run pending), done=0, start_ack=0, heartbeat=0, cycle_count=0. Internal state: state=PRE, mask=all ones, counters=0.
- Trigger edge T:
  - Power-on: the first edge sampling reset=0.
  - Software: the edge sampling start_req=1 while in IDLE.
- FSM IDLE -> PRE -> ASSERT -> RELEASE -> IDLE.
  - PRE: rst_out=0. rst_out becomes the mask at edge T+PRE_CYCLES.
  - ASSERT/RELEASE: bit i falls at edge T+PRE_CYCLES+ASSERT_CYCLES+i*STAGGER_CYCLES.
  - Release timing uses the absolute channel index, independent of the mask. Unmasked bits stay 0 throughout.
- At the last release edge (i=NUM_CH-1): done=1 for one cycle, busy=0, state=IDLE.
- mask=0: timing runs unchanged, rst_out stays 0, done still pulses.
- Handshake: start_req accepted only in IDLE. At the accept edge: start_ack=1 for one cycle, ch_mask latched, busy=1.
  - start_req while busy: ignored, no ack, not queued.
  - A req sampled at the done edge is ignored. If still held, it is accepted on the next edge.
- Reset mid-sequence: at the next edge rst_out=0 and busy=1. The power-on run restarts with the full mask once reset is released.
- cycle_count increments every edge with reset=0, and equals 1 after edge T0.
- heartbeat=1 for one cycle after each edge where cycle_count becomes a nonzero multiple of HEARTBEAT_PERIOD. An internal modulo counter is used, not a divider. The heartbeat counter is cleared by reset only.
- Software runs do not disturb cycle_count or heartbeat.

Test Plan:
- Power-on, defaults: reset high 3 cycles, release at T0 -> rst_out=4'b0000 through T0+2, 4'b1111 at T0+3. Bits fall at T0+6 (bit0), T0+8 (bit1), T0+10 (bit2), T0+12 (bit3). done pulse and busy=0 at T0+12.
- Software run: ch_mask=4'b0101, start_req accepted at edge S in IDLE -> start_ack pulse at S. rst_out=4'b0101 at S+3. Bit0 falls at S+6, bit2 at S+10. done at S+12. Bits 1 and 3 stay 0 throughout.
- Busy collision: start_req held high from S+4 -> no ack during the run, none at the done edge S+12. Accepted at S+13 with a fresh ch_mask, start_ack pulse at S+13.
- Mid-sequence reset: reset asserted at T0+7 for 2 cycles -> rst_out=0 at T0+8, busy=1. Full power-on sequence repeats from the new release edge with mask 4'b1111.
- Heartbeat: 350 cycles after release, no other activity -> exactly 3 heartbeat pulses, at cycle_count=100, 200 and 300. cycle_count=350. Pulses are unaffected by a software run started at cycle 150.
- STAGGER_CYCLES=0, mask=4'b0000 variant: rst_out stays 0. Software run started at S gives done at S+6 and busy=0 at S+6.
